// File: rtl/pattern_gen.sv
// Video test-pattern generator: turns timing-generator sync/coordinate inputs into 24-bit RGB
// through a fixed two-stage pipeline, with syncs delayed to stay aligned with the colour.
module pattern_gen #(
   parameter int X_BITS    = 12,
   parameter int Y_BITS    = 12,
   parameter int H_ACT     = 1280,
   parameter int V_ACT     = 720,
   parameter int GRID_LOG2 = 5,
   parameter int BOX_SIZE  = 64,
   parameter int BOX_STEP  = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [1:0]        mode_i,
   input  logic              vs_in,
   input  logic              hs_in,
   input  logic              de_in,
   input  logic [X_BITS-1:0] x_in,
   input  logic [Y_BITS:0]   y_in,
   output logic              vs_out,
   output logic              hs_out,
   output logic              de_out,
   output logic [7:0]        r_out,
   output logic [7:0]        g_out,
   output logic [7:0]        b_out,
   output logic [15:0]       frame_cnt
);

   typedef enum logic [1:0] {
      MODE_BARS = 2'd0,
      MODE_GRID = 2'd1,
      MODE_RAMP = 2'd2,
      MODE_BOX  = 2'd3
   } mode_t;

   typedef enum logic {
      DIR_POS = 1'b0,
      DIR_NEG = 1'b1
   } dir_t;

   localparam int XW    = X_BITS + 1;
   localparam int YW    = Y_BITS + 2;
   localparam int BAR_W = H_ACT >> 3;

   localparam logic [XW-1:0]       LIM_X_W  = XW'(H_ACT - BOX_SIZE);
   localparam logic [YW-1:0]       LIM_Y_W  = YW'(V_ACT - BOX_SIZE);
   localparam logic [X_BITS-1:0]   LIM_X    = X_BITS'(H_ACT - BOX_SIZE);
   localparam logic [Y_BITS:0]     LIM_Y    = (Y_BITS + 1)'(V_ACT - BOX_SIZE);
   localparam logic [XW-1:0]       STEP_XW  = XW'(BOX_STEP);
   localparam logic [YW-1:0]       STEP_YW  = YW'(BOX_STEP);
   localparam logic [X_BITS-1:0]   STEP_X   = X_BITS'(BOX_STEP);
   localparam logic [Y_BITS:0]     STEP_Y   = (Y_BITS + 1)'(BOX_STEP);
   localparam logic [XW-1:0]       SIZE_XW  = XW'(BOX_SIZE);
   localparam logic [YW-1:0]       SIZE_YW  = YW'(BOX_SIZE);
   localparam logic [X_BITS-1:0]   LAST_X   = X_BITS'(H_ACT - 1);
   localparam logic [Y_BITS:0]     LAST_Y   = (Y_BITS + 1)'(V_ACT - 1);
   localparam logic [X_BITS-1:0]   BAR_LAST = X_BITS'(BAR_W - 1);

   logic              vs_d;
   logic              de_prev;
   logic              fs;
   logic              de_rise;
   mode_t             mode_q;

   logic [X_BITS-1:0] box_x;
   logic [Y_BITS:0]   box_y;
   dir_t              dir_x;
   dir_t              dir_y;
   logic [X_BITS-1:0] box_x_nxt;
   logic [Y_BITS:0]   box_y_nxt;
   dir_t              dir_x_nxt;
   dir_t              dir_y_nxt;

   logic [X_BITS-1:0] px_cnt;
   logic [2:0]        bar_idx;
   logic [X_BITS-1:0] px_cur;
   logic [2:0]        bar_cur;
   logic [X_BITS-1:0] px_nxt;
   logic [2:0]        bar_nxt;

   logic              grid_hit;
   logic              box_hit;
   logic [XW-1:0]     x_ext;
   logic [YW-1:0]     y_ext;
   logic [XW-1:0]     box_x_ext;
   logic [YW-1:0]     box_y_ext;

   logic              s1_vs;
   logic              s1_hs;
   logic              s1_de;
   mode_t             s1_mode;
   logic [2:0]        s1_bar;
   logic              s1_grid;
   logic [7:0]        s1_ramp;
   logic              s1_box;
   logic [23:0]       rgb_nxt;

   assign fs      = vs_in & ~vs_d;
   assign de_rise = de_in & ~de_prev;

   // Frame-level state: mode is only sampled at frame start so a pattern never tears mid-frame.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vs_d      <= 1'b0;
         de_prev   <= 1'b0;
         mode_q    <= MODE_BARS;
         frame_cnt <= 16'd0;
         box_x     <= '0;
         box_y     <= '0;
         dir_x     <= DIR_POS;
         dir_y     <= DIR_POS;
      end else begin
         vs_d    <= vs_in;
         de_prev <= de_in;
         if (fs) begin
            mode_q    <= mode_t'(mode_i);
            frame_cnt <= frame_cnt + 16'd1;
            box_x     <= box_x_nxt;
            box_y     <= box_y_nxt;
            dir_x     <= dir_x_nxt;
            dir_y     <= dir_y_nxt;
         end
      end
   end

   assign box_x_ext = {1'b0, box_x};
   assign box_y_ext = {1'b0, box_y};

   always_comb begin
      box_x_nxt = box_x;
      dir_x_nxt = dir_x;
      if (dir_x == DIR_POS) begin
         if (box_x_ext + STEP_XW >= LIM_X_W) begin
            box_x_nxt = LIM_X;
            dir_x_nxt = DIR_NEG;
         end else begin
            box_x_nxt = box_x + STEP_X;
         end
      end else begin
         if (box_x_ext <= STEP_XW) begin
            box_x_nxt = '0;
            dir_x_nxt = DIR_POS;
         end else begin
            box_x_nxt = box_x - STEP_X;
         end
      end
   end

   always_comb begin
      box_y_nxt = box_y;
      dir_y_nxt = dir_y;
      if (dir_y == DIR_POS) begin
         if (box_y_ext + STEP_YW >= LIM_Y_W) begin
            box_y_nxt = LIM_Y;
            dir_y_nxt = DIR_NEG;
         end else begin
            box_y_nxt = box_y + STEP_Y;
         end
      end else begin
         if (box_y_ext <= STEP_YW) begin
            box_y_nxt = '0;
            dir_y_nxt = DIR_POS;
         end else begin
            box_y_nxt = box_y - STEP_Y;
         end
      end
   end

   // The first pixel of a line sees a cleared counter in the same cycle as the de rising edge.
   always_comb begin
      px_cur  = de_rise ? '0 : px_cnt;
      bar_cur = de_rise ? 3'd0 : bar_idx;
      px_nxt  = px_cur;
      bar_nxt = bar_cur;
      if (de_in) begin
         if (px_cur == BAR_LAST) begin
            px_nxt  = '0;
            bar_nxt = (bar_cur == 3'd7) ? 3'd7 : bar_cur + 3'd1;
         end else begin
            px_nxt  = px_cur + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         px_cnt  <= '0;
         bar_idx <= 3'd0;
      end else begin
         px_cnt  <= px_nxt;
         bar_idx <= bar_nxt;
      end
   end

   assign x_ext = {1'b0, x_in};
   assign y_ext = {1'b0, y_in};

   always_comb begin
      grid_hit = (x_in[GRID_LOG2-1:0] == '0) || (y_in[GRID_LOG2-1:0] == '0) ||
                 (x_in == LAST_X) || (y_in == LAST_Y);
      box_hit  = (x_ext >= box_x_ext) && (x_ext < box_x_ext + SIZE_XW) &&
                 (y_ext >= box_y_ext) && (y_ext < box_y_ext + SIZE_YW);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_vs   <= 1'b0;
         s1_hs   <= 1'b0;
         s1_de   <= 1'b0;
         s1_mode <= MODE_BARS;
         s1_bar  <= 3'd0;
         s1_grid <= 1'b0;
         s1_ramp <= 8'd0;
         s1_box  <= 1'b0;
      end else begin
         s1_vs   <= vs_in;
         s1_hs   <= hs_in;
         s1_de   <= de_in;
         s1_mode <= mode_q;
         s1_bar  <= bar_cur;
         s1_grid <= grid_hit;
         s1_ramp <= x_in[7:0];
         s1_box  <= box_hit;
      end
   end

   always_comb begin
      rgb_nxt = 24'h000000;
      if (s1_de) begin
         case (s1_mode)
            MODE_BARS: begin
               case (s1_bar)
                  3'd0:    rgb_nxt = 24'hFFFFFF;
                  3'd1:    rgb_nxt = 24'hFFFF00;
                  3'd2:    rgb_nxt = 24'h00FFFF;
                  3'd3:    rgb_nxt = 24'h00FF00;
                  3'd4:    rgb_nxt = 24'hFF00FF;
                  3'd5:    rgb_nxt = 24'hFF0000;
                  3'd6:    rgb_nxt = 24'h0000FF;
                  default: rgb_nxt = 24'h000000;
               endcase
            end
            MODE_GRID: rgb_nxt = s1_grid ? 24'hFFFFFF : 24'h000000;
            MODE_RAMP: rgb_nxt = {s1_ramp, s1_ramp, s1_ramp};
            default:   rgb_nxt = s1_box ? 24'hFF0000 : 24'h000040;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vs_out <= 1'b0;
         hs_out <= 1'b0;
         de_out <= 1'b0;
         r_out  <= 8'd0;
         g_out  <= 8'd0;
         b_out  <= 8'd0;
      end else begin
         vs_out <= s1_vs;
         hs_out <= s1_hs;
         de_out <= s1_de;
         r_out  <= rgb_nxt[23:16];
         g_out  <= rgb_nxt[15:8];
         b_out  <= rgb_nxt[7:0];
      end
   end

endmodule

// File: tb/tb_pattern_gen.sv
// Directed testbench for pattern_gen: drives lines and frame starts, compares against
// hand-computed colours, sync delays and frame counts.
module tb_pattern_gen;

   localparam int H_ACT = 1280;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic [1:0]  mode_i = 2'd0;
   logic        vs_in = 1'b0;
   logic        hs_in = 1'b0;
   logic        de_in = 1'b0;
   logic [11:0] x_in = '0;
   logic [12:0] y_in = '0;
   logic        vs_out;
   logic        hs_out;
   logic        de_out;
   logic [7:0]  r_out;
   logic [7:0]  g_out;
   logic [7:0]  b_out;
   logic [15:0] frame_cnt;

   int vectors = 0;
   int miscompares = 0;

   logic [23:0] line_rgb [0:H_ACT];
   logic        line_de  [0:H_ACT];

   int          bar_x   [14] = '{0, 159, 160, 320, 480, 640, 800, 960, 1119, 1120, 1279, 1280, 500, 319};
   logic [23:0] bar_rgb [14] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h0000FF, 24'h000000,
                                 24'h000000, 24'h000000, 24'h00FF00, 24'hFFFF00};

   logic [11:0] lat_x   [4] = '{12'd5, 12'd32, 12'd300, 12'd16};
   logic [12:0] lat_y   [4] = '{13'd3, 13'd5, 13'd3, 13'd16};
   logic [23:0] lat_rgb [4] = '{24'hFFFFFF, 24'hFFFFFF, 24'h2C2C2C, 24'hFF0000};

   always #5 clk = ~clk;

   pattern_gen dut (
      .clk       (clk),
      .rstn      (rstn),
      .mode_i    (mode_i),
      .vs_in     (vs_in),
      .hs_in     (hs_in),
      .de_in     (de_in),
      .x_in      (x_in),
      .y_in      (y_in),
      .vs_out    (vs_out),
      .hs_out    (hs_out),
      .de_out    (de_out),
      .r_out     (r_out),
      .g_out     (g_out),
      .b_out     (b_out),
      .frame_cnt (frame_cnt)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic h, input logic d,
                                input logic [11:0] x, input logic [12:0] y);
      vs_in = v;
      hs_in = h;
      de_in = d;
      x_in  = x;
      y_in  = y;
   endtask

   // Outputs seen at a falling edge belong to the inputs driven two falling edges earlier.
   task automatic drive_line(input logic [12:0] y);
      for (int i = 0; i < H_ACT + 3; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            line_rgb[i-2] = {r_out, g_out, b_out};
            line_de[i-2]  = de_out;
         end
         if (i < H_ACT) applyStimulus(1'b0, 1'b0, 1'b1, 12'(i), y);
         else           applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 13'd0);
      end
   endtask

   task automatic frame_start();
      @(negedge clk) applyStimulus(1'b1, 1'b0, 1'b0, 12'd0, 13'd0);
      @(negedge clk) applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 13'd0);
   endtask

   task automatic pulse_check(input string tag, input logic v, input logic h, input logic d,
                              input logic [11:0] x, input logic [12:0] y, input logic [23:0] exp_rgb);
      logic [2:0]  s1, s2, s3;
      logic [23:0] rgb2;
      @(negedge clk) applyStimulus(v, h, d, x, y);
      @(negedge clk) s1 = {vs_out, hs_out, de_out};
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 13'd0);
      @(negedge clk) s2 = {vs_out, hs_out, de_out};
      rgb2 = {r_out, g_out, b_out};
      @(negedge clk) s3 = {vs_out, hs_out, de_out};
      checkOutput({tag, "_c1"}, 32'(s1), 32'd0);
      checkOutput({tag, "_c2"}, 32'(s2), 32'({v, h, d}));
      checkOutput({tag, "_c3"}, 32'(s3), 32'd0);
      checkOutput({tag, "_rgb"}, 32'(rgb2), 32'(exp_rgb));
   endtask

   initial begin
      #1 rstn = 1'b0;
      #2;
      checkOutput("rst_rgb", 32'({r_out, g_out, b_out}), 32'd0);
      checkOutput("rst_sync", 32'({vs_out, hs_out, de_out}), 32'd0);
      checkOutput("rst_fcnt", 32'(frame_cnt), 32'd0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      mode_i = 2'd2;
      repeat (2) @(negedge clk);

      // No frame start yet, so bars regardless of mode_i
      drive_line(13'd10);
      for (int k = 0; k < 12; k++)
         checkOutput($sformatf("bars_x%0d", bar_x[k]), 32'(line_rgb[bar_x[k]]), 32'(bar_rgb[k]));
      checkOutput("bars_de_last", 32'(line_de[H_ACT-1]), 32'd1);
      checkOutput("bars_de_blank", 32'(line_de[H_ACT]), 32'd0);
      drive_line(13'd11);
      checkOutput("bars_restart_x0", 32'(line_rgb[0]), 32'hFFFFFF);
      for (int k = 12; k < 14; k++)
         checkOutput($sformatf("bars2_x%0d", bar_x[k]), 32'(line_rgb[bar_x[k]]), 32'(bar_rgb[k]));

      for (int m = 0; m < 4; m++) begin
         mode_i = 2'(m);
         pulse_check($sformatf("vs_lat_m%0d", m), 1'b1, 1'b0, 1'b0, 12'd0, 13'd0, 24'h0);
         checkOutput($sformatf("fcnt_m%0d", m), 32'(frame_cnt), 32'(m + 1));
         pulse_check($sformatf("hs_lat_m%0d", m), 1'b0, 1'b1, 1'b0, 12'd0, 13'd0, 24'h0);
         pulse_check($sformatf("de_lat_m%0d", m), 1'b0, 1'b0, 1'b1, lat_x[m], lat_y[m], lat_rgb[m]);
      end

      mode_i = 2'd0;
      frame_start();
      drive_line(13'd5);
      checkOutput("sw_bars_x33", 32'(line_rgb[33]), 32'hFFFFFF);
      mode_i = 2'd1;
      drive_line(13'd5);
      checkOutput("sw_hold_x160", 32'(line_rgb[160]), 32'hFFFF00);
      checkOutput("sw_hold_x33", 32'(line_rgb[33]), 32'hFFFFFF);
      frame_start();
      drive_line(13'd5);
      checkOutput("grid_x32", 32'(line_rgb[32]), 32'hFFFFFF);
      checkOutput("grid_x33", 32'(line_rgb[33]), 32'h000000);
      checkOutput("grid_x160", 32'(line_rgb[160]), 32'hFFFFFF);
      checkOutput("grid_x1279", 32'(line_rgb[1279]), 32'hFFFFFF);
      drive_line(13'd719);
      checkOutput("grid_y719", 32'(line_rgb[33]), 32'hFFFFFF);
      checkOutput("fcnt_6", 32'(frame_cnt), 32'd6);

      // Box reaches the right limit on frame 304; y has bounced off 656 and is back at 96
      mode_i = 2'd3;
      repeat (298) frame_start();
      checkOutput("fcnt_304", 32'(frame_cnt), 32'd304);
      drive_line(13'd96);
      checkOutput("box_1216_96", 32'(line_rgb[1216]), 32'hFF0000);
      checkOutput("box_1215_96", 32'(line_rgb[1215]), 32'h000040);
      checkOutput("box_1279_96", 32'(line_rgb[1279]), 32'hFF0000);
      drive_line(13'd95);
      checkOutput("box_1216_95", 32'(line_rgb[1216]), 32'h000040);
      drive_line(13'd159);
      checkOutput("box_1216_159", 32'(line_rgb[1216]), 32'hFF0000);
      drive_line(13'd160);
      checkOutput("box_1216_160", 32'(line_rgb[1216]), 32'h000040);
      frame_start();
      drive_line(13'd92);
      checkOutput("box_1212_92", 32'(line_rgb[1212]), 32'hFF0000);
      checkOutput("box_1211_92", 32'(line_rgb[1211]), 32'h000040);
      checkOutput("box_1275_92", 32'(line_rgb[1275]), 32'hFF0000);
      checkOutput("box_1276_92", 32'(line_rgb[1276]), 32'h000040);
      checkOutput("fcnt_305", 32'(frame_cnt), 32'd305);

      mode_i = 2'd2;
      frame_start();
      drive_line(13'd7);
      checkOutput("ramp_x300", 32'(line_rgb[300]), 32'h2C2C2C);
      checkOutput("ramp_x255", 32'(line_rgb[255]), 32'hFFFFFF);
      checkOutput("ramp_x256", 32'(line_rgb[256]), 32'h000000);
      checkOutput("ramp_x1", 32'(line_rgb[1]), 32'h010101);
      checkOutput("fcnt_306", 32'(frame_cnt), 32'd306);

      // Reset in the middle of an active line
      @(negedge clk) applyStimulus(1'b0, 1'b0, 1'b1, 12'd300, 13'd7);
      @(negedge clk) applyStimulus(1'b0, 1'b0, 1'b1, 12'd300, 13'd7);
      @(negedge clk);
      checkOutput("pre_rst_rgb", 32'({r_out, g_out, b_out}), 32'h2C2C2C);
      #2 rstn = 1'b0;
      #1;
      checkOutput("midrst_rgb", 32'({r_out, g_out, b_out}), 32'd0);
      checkOutput("midrst_sync", 32'({vs_out, hs_out, de_out}), 32'd0);
      checkOutput("midrst_fcnt", 32'(frame_cnt), 32'd0);
      repeat (2) @(negedge clk);
      checkOutput("midrst_hold", 32'({de_out, r_out, g_out, b_out}), 32'd0);
      rstn = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 13'd0);
      repeat (2) @(negedge clk);
      drive_line(13'd7);
      checkOutput("postrst_x0", 32'(line_rgb[0]), 32'hFFFFFF);
      checkOutput("postrst_x300", 32'(line_rgb[300]), 32'hFFFF00);
      checkOutput("postrst_fcnt", 32'(frame_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
